si_packet_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares one 128-bit AXI4-Stream time-tag packet path, i.e. the header parser input, between several Ethernet receive streams, such as multiple SFP/QSFP lanes or Time Tagger links. Grant is held for a whole packet, from its first accepted beat to its `tlast` beat, so downstream header validation and sequence checking always see contiguous packets from one source. The block sits between the per-lane MAC/FIFO outputs and `si_header_parser`.

---
 rtl/si_packet_arbiter_if.sv | 12 +
 rtl/si_packet_arbiter.sv | 177 +++++++++++++++++
 tb/tb_si_packet_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/si_packet_arbiter_if.sv
// axis_interface: 128-bit AXI4-Stream bundle (data, keep, last, valid/ready)
// used for both the input lanes and the output of si_packet_arbiter.
interface axis_interface;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/si_packet_arbiter.sv
// si_packet_arbiter: packet-atomic round-robin arbiter feeding si_header_parser.
// Optional per-port packet counters are enabled with `define SI_ARB_PKT_COUNT_EN.
module si_packet_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  axis_interface.slave     s_axis [NUM_PORTS],
  axis_interface.master    m_axis,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
`ifdef SI_ARB_PKT_COUNT_EN
  ,
  output logic [31:0]      pkt_count [NUM_PORTS]
`endif
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 r_busy;
  logic                 w_any_valid;
  logic                 w_grant_load;
  logic                 w_pkt_done;
  logic [NUM_PORTS-1:0] w_tvalid;
  logic [NUM_PORTS-1:0] w_tlast;
  logic [NUM_PORTS-1:0] w_tready;
  logic [127:0]         w_tdata [NUM_PORTS];
  logic [15:0]          w_tkeep [NUM_PORTS];
  logic [127:0]         w_g_tdata;
  logic [15:0]          w_g_tkeep;
  logic                 w_g_tvalid;
  logic                 w_g_tlast;

  // Interface arrays only take constant indices, so flatten them here.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_tvalid[gi]       = s_axis[gi].tvalid;
    assign w_tlast[gi]        = s_axis[gi].tlast;
    assign w_tdata[gi]        = s_axis[gi].tdata;
    assign w_tkeep[gi]        = s_axis[gi].tkeep;
    assign s_axis[gi].tready  = w_tready[gi];
  end

  // Round-robin pick: first valid port at or above r_rr_ptr, else lowest valid.
  always_comb begin
    w_any_valid = 1'b0;
    w_pick_idx  = {IDX_W{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!w_any_valid && w_tvalid[p] && (IDX_W'(p) >= r_rr_ptr)) begin
        w_any_valid = 1'b1;
        w_pick_idx  = IDX_W'(p);
      end else begin
        w_any_valid = w_any_valid;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!w_any_valid && w_tvalid[p]) begin
        w_any_valid = 1'b1;
        w_pick_idx  = IDX_W'(p);
      end else begin
        w_any_valid = w_any_valid;
      end
    end
  end

  // Select the granted lane's beat.
  always_comb begin
    w_g_tdata  = 128'd0;
    w_g_tkeep  = 16'd0;
    w_g_tvalid = 1'b0;
    w_g_tlast  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant_idx == IDX_W'(p)) begin
        w_g_tdata  = w_tdata[p];
        w_g_tkeep  = w_tkeep[p];
        w_g_tvalid = w_tvalid[p];
        w_g_tlast  = w_tlast[p];
      end else begin
        w_g_tvalid = w_g_tvalid;
      end
    end
  end

  // Next state and the combinational datapath / ready fan-out.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_load  = 1'b0;
    w_pkt_done    = 1'b0;
    w_tready      = {NUM_PORTS{1'b0}};
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = 128'd0;
    m_axis.tkeep  = 16'd0;
    m_axis.tlast  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_grant_load = 1'b1;
          w_state_nxt  = ST_BUSY;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        m_axis.tvalid = w_g_tvalid;
        m_axis.tdata  = w_g_tdata;
        m_axis.tkeep  = w_g_tkeep;
        m_axis.tlast  = w_g_tlast;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (r_grant_idx == IDX_W'(p)) begin
            w_tready[p] = m_axis.tready;
          end else begin
            w_tready[p] = 1'b0;
          end
        end
        if (w_g_tvalid && m_axis.tready && w_g_tlast) begin
          w_pkt_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_grant_idx <= {IDX_W{1'b0}};
      r_rr_ptr    <= {IDX_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_BUSY);
      if (w_grant_load) begin
        r_grant_idx <= w_pick_idx;
      end
      if (w_pkt_done) begin
        r_rr_ptr <= (r_grant_idx == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}}
                                                           : r_grant_idx + IDX_W'(1);
      end
    end
  end

  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;

`ifdef SI_ARB_PKT_COUNT_EN
  logic [31:0] r_pkt_count [NUM_PORTS];

  // Per-port packet counters, bumped on the tlast handshake and wrapping freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_pkt_count[p] <= 32'd0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_pkt_done && (r_grant_idx == IDX_W'(p))) begin
          r_pkt_count[p] <= r_pkt_count[p] + 32'd1;
        end
      end
    end
  end

  for (genvar gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
    assign pkt_count[gc] = r_pkt_count[gc];
  end
`endif
endmodule

// File: tb/tb_si_packet_arbiter.sv
// Testbench for si_packet_arbiter: directed vector table, corner-case sequences
// and randomized traffic checked against a cycle-level reference model.
module tb_si_packet_arbiter;
  localparam int NP = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    logic          rst;
    logic [NP-1:0] valid;
    logic [NP-1:0] last;
    logic          rdy;
    logic          busy;
    logic [IW-1:0] gidx;
    logic          mvalid;
    logic          mlast;
    logic [NP-1:0] trdy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_rst;
  logic [NP-1:0] in_valid;
  logic [NP-1:0] in_last;
  logic [127:0]  in_data [NP];
  logic [15:0]   in_keep [NP];
  logic          in_rdy;
  logic [NP-1:0] act_trdy;
  logic          busy;
  logic [IW-1:0] gidx;
`ifdef SI_ARB_PKT_COUNT_EN
  logic [31:0]   pkt_count [NP];
`endif

  axis_interface s_if [NP] ();
  axis_interface m_if ();

  for (genvar g = 0; g < NP; g++) begin : g_src
    assign s_if[g].tvalid = in_valid[g];
    assign s_if[g].tdata  = in_data[g];
    assign s_if[g].tkeep  = in_keep[g];
    assign s_if[g].tlast  = in_last[g];
    assign act_trdy[g]    = s_if[g].tready;
  end
  assign m_if.tready = in_rdy;

  si_packet_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst       (in_rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .busy      (busy),
    .grant_idx (gidx)
`ifdef SI_ARB_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_busy = 0;
  int          m_gnt  = 0;
  int          m_ptr  = 0;
  logic [31:0] m_cnt [NP];
  int          cur_hs = -1;
  int          last_hs = -1;

  // Sources and scoreboard
  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  int    pkt_no [NP];
  int    sb_cnt [NP];
  bit    gate [NP];
  bit    sb_en = 1'b0;
  bit    rnd_v = 1'b0;
  bit    rnd_r = 1'b0;
  int    glog [$];
  int    busy_cyc = 0;
  logic  prev_busy = 1'b0;
  vec_t  tv [15];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step_check();
    logic [NP-1:0] e_trdy;
    logic          e_mv;
    int            pi;
    beat_t         b;
    #3;
    e_trdy = '0;
    e_mv   = 1'b0;
    cur_hs = -1;
    if (m_busy != 0) begin
      e_trdy[m_gnt] = in_rdy;
      e_mv          = in_valid[m_gnt];
    end
    chk("busy", busy, m_busy);
    chk("grant_idx", gidx, m_gnt);
    chk("m_tvalid", m_if.tvalid, e_mv);
    chk("s_tready", act_trdy, e_trdy);
    if (e_mv) begin
      chk("m_tdata", m_if.tdata, in_data[m_gnt]);
      chk("m_tkeep", m_if.tkeep, in_keep[m_gnt]);
      chk("m_tlast", m_if.tlast, in_last[m_gnt]);
      if (in_rdy) begin
        cur_hs = m_gnt;
        if (sb_en) begin
          pi = int'(m_if.tdata[127:120]);
          if (pi < NP && exp_q[pi].size() > 0) begin
            b = exp_q[pi].pop_front();
            sb_cnt[pi]++;
            chk("sb_data", m_if.tdata, b.data);
            chk("sb_keep_last", {m_if.tkeep, m_if.tlast}, {b.keep, b.last});
          end else begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: beat tag %0d has no pending beat", pi);
          end
        end
      end
    end
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b1 && prev_busy !== 1'b1) glog.push_back(int'(gidx));
    prev_busy = busy;
`ifdef SI_ARB_PKT_COUNT_EN
    for (int p = 0; p < NP; p++) chk($sformatf("pkt_count%0d", p), pkt_count[p], m_cnt[p]);
`endif
  endtask

  // Model update from the arbitration rules, applied at the clock edge.
  task automatic step_edge();
    @(posedge clk);
    if (in_rst) begin
      m_busy = 0;
      m_gnt  = 0;
      m_ptr  = 0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 32'd0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < NP; k++) begin
        if (m_busy == 0 && in_valid[(m_ptr + k) % NP]) begin
          m_gnt  = (m_ptr + k) % NP;
          m_busy = 1;
        end
      end
    end else if (cur_hs >= 0 && in_last[m_gnt]) begin
      m_cnt[m_gnt] = m_cnt[m_gnt] + 32'd1;
      m_busy = 0;
      m_ptr  = (m_gnt + 1) % NP;
    end
    last_hs = cur_hs;
    #1;
  endtask

  task automatic fill();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        in_data[p]  = src_q[p][0].data;
        in_keep[p]  = src_q[p][0].keep;
        in_last[p]  = src_q[p][0].last;
        in_valid[p] = gate[p] && (!rnd_v || ($urandom_range(3) != 0));
      end else begin
        in_data[p]  = 128'd0;
        in_keep[p]  = 16'd0;
        in_last[p]  = 1'b0;
        in_valid[p] = 1'b0;
      end
    end
    in_rdy = rnd_r ? 1'($urandom_range(1)) : 1'b1;
  endtask

  task automatic qstep();
    fill();
    step_check();
    step_edge();
    if (last_hs >= 0 && src_q[last_hs].size() > 0) src_q[last_hs].delete(0);
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += src_q[p].size();
    return n;
  endfunction

  task automatic run_until_empty(input int budget, output int cyc);
    cyc = 0;
    while (pending() > 0 && cyc < budget) begin
      qstep();
      cyc++;
    end
    if (pending() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d beats still queued after %0d cycles", pending(), cyc);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 8'(pkt_no[p]), 16'(i), $urandom, $urandom, $urandom};
      b.keep = 16'($urandom);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    pkt_no[p]++;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    qstep();
    qstep();
    in_rst = 1'b0;
    glog.delete();
    busy_cyc = 0;
    rnd_v = 1'b0;
    rnd_r = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sb_cnt[p] = 0;
      gate[p]   = 1'b1;
    end
  endtask

  task automatic chk_glog(input string nm, input int exp_list [$]);
    chk({nm, "_count"}, glog.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < glog.size(); i++)
      chk($sformatf("%s_%0d", nm, i), glog[i], exp_list[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    in_rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_rdy = 1'b0;
    for (int p = 0; p < NP; p++) begin
      in_data[p] = {8'(p), 8'hCD, 112'(p * 7 + 1)};
      in_keep[p] = 16'hFFFF;
      m_cnt[p]   = 32'd0;
      pkt_no[p]  = 0;
      sb_cnt[p]  = 0;
      gate[p]    = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", gidx, 2'd0);
    chk("reset_mvalid", m_if.tvalid, 1'b0);
    chk("reset_tready", act_trdy, 4'b0000);

    //        rst   valid    last     rdy   busy  gidx  mv    mlast trdy
    tv[0]  = '{1'b0, 4'b0011, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[1]  = '{1'b0, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001};
    tv[2]  = '{1'b0, 4'b0011, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000};
    tv[3]  = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001};
    tv[4]  = '{1'b0, 4'b0011, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[5]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0010};
    tv[6]  = '{1'b0, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010};
    tv[7]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000};
    tv[8]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001};
    tv[9]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[10] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'b1000};
    tv[11] = '{1'b0, 4'b1010, 4'b1010, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0000};
    tv[12] = '{1'b1, 4'b1010, 4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010};
    tv[13] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[14] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010};

    for (int i = 0; i < 15; i++) begin
      in_rst   = tv[i].rst;
      in_valid = tv[i].valid;
      in_last  = tv[i].last;
      in_rdy   = tv[i].rdy;
      step_check();
      chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("tv%0d_gidx", i), gidx, tv[i].gidx);
      chk($sformatf("tv%0d_mvalid", i), m_if.tvalid, tv[i].mvalid);
      chk($sformatf("tv%0d_tready", i), act_trdy, tv[i].trdy);
      if (tv[i].mvalid) begin
        chk($sformatf("tv%0d_mlast", i), m_if.tlast, tv[i].mlast);
        chk($sformatf("tv%0d_mdata", i), m_if.tdata, in_data[tv[i].gidx]);
      end
      step_edge();
    end
    in_rst = 1'b0;
    sb_en  = 1'b1;

    // Single port, 4-beat packet
    do_reset();
    add_pkt(0, 4);
    run_until_empty(50, cyc);
    chk("single_cycles", cyc, 5);
    chk("single_busy_cycles", busy_cyc, 4);
    chk_glog("single_grant", '{0});
`ifdef SI_ARB_PKT_COUNT_EN
    chk("single_pkt_count", pkt_count[0], 32'd1);
`endif

    // Two ports with 3-beat packets pending from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_pkt(0, 3);
      add_pkt(1, 3);
    end
    run_until_empty(100, cyc);
    chk("simul_cycles", cyc, 16);
    chk_glog("simul_grant", '{0, 1, 0, 1});

    // Mid-packet stall on port 1 while port 0 waits
    do_reset();
    add_pkt(1, 4);
    add_pkt(0, 2);
    gate[0] = 1'b0;
    qstep();
    gate[0] = 1'b1;
    qstep();
    qstep();
    gate[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fill();
      step_check();
      chk("stall_busy", busy, 1'b1);
      chk("stall_p0_tready", act_trdy[0], 1'b0);
      step_edge();
      if (last_hs >= 0 && src_q[last_hs].size() > 0) src_q[last_hs].delete(0);
    end
    gate[1] = 1'b1;
    run_until_empty(100, cyc);
    chk_glog("stall_grant", '{1, 0});

    // Random backpressure during an 8-beat packet on port 2
    do_reset();
    add_pkt(2, 8);
    rnd_r = 1'b1;
    run_until_empty(300, cyc);
    chk("bp_beats", sb_cnt[2], 8);

    // Single-word packets from three ports back to back
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++) add_pkt(p, 1);
    run_until_empty(100, cyc);
    chk("sw_cycles", cyc, 12);
    chk_glog("sw_grant", '{0, 1, 2, 0, 1, 2});

    // Reset asserted during beat 3 of a 6-beat packet
    do_reset();
    add_pkt(3, 6);
    add_pkt(1, 2);
    gate[1] = 1'b0;
    qstep();
    gate[1] = 1'b1;
    qstep();
    qstep();
    fill();
    in_rst = 1'b1;
    step_check();
    step_edge();
    if (last_hs >= 0 && src_q[last_hs].size() > 0) src_q[last_hs].delete(0);
    in_rst = 1'b0;
    glog.delete();
    fill();
    step_check();
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_tready", act_trdy, 4'b0000);
    step_edge();
    if (last_hs >= 0 && src_q[last_hs].size() > 0) src_q[last_hs].delete(0);
    run_until_empty(100, cyc);
    chk_glog("rstmid_grant", '{1, 3});

`ifdef SI_ARB_PKT_COUNT_EN
    dut.r_pkt_count[0] = 32'hFFFFFFFF;
    m_cnt[0] = 32'hFFFFFFFF;
    add_pkt(0, 1);
    run_until_empty(20, cyc);
    chk("cnt_wrap", pkt_count[0], 32'd0);
`endif

    // Randomized traffic on all ports
    do_reset();
    rnd_v = 1'b1;
    rnd_r = 1'b1;
    for (int k = 0; k < 6; k++)
      for (int p = 0; p < NP; p++) add_pkt(p, $urandom_range(8, 1));
    run_until_empty(3000, cyc);
    for (int p = 0; p < NP; p++) chk($sformatf("sb_left%0d", p), exp_q[p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
